vram_stroke_writer: RTL and testbench

- Write-side owner of the VRAM block_ram port (wr_ena/wr_addr/wr_data); the display controller owns the read side.
- After reset or on request, clears every VRAM word to CLEAR_COLOR.
- Otherwise stamps a square brush of pen_color centred on each new valid touch coordinate.
- Sits between the ft6206 touch controller output and the VRAM.

---
 rtl/vram_stroke_writer.sv | 202 ++++++++++++++++++++
 tb/tb_vram_stroke_writer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vram_stroke_writer.sv
// ----------------------------------------------------------------------------
// vram_stroke_writer
//
// This block drives the write port of the VRAM block RAM. The display
// controller owns the read port.
//   - After reset, or when clear_req is seen, it writes CLEAR_COLOR to every
//     VRAM word.
//   - Otherwise it stamps a square brush of the latched pen colour, centred on
//     each new touch coordinate that is valid and in range.
//
// Ports
//   clk           system clock; all logic runs on posedge
//   rst           asynchronous, active-high reset
//   clear_req     level; when seen in idle or paint, starts a full clear
//   touch_valid   touch point valid (from the touch controller)
//   touch_x/y     touch coordinate, 9 bits each
//   pen_color     brush colour; sampled when a stamp is accepted
//   vram_wr_ena   VRAM write enable (registered)
//   vram_wr_addr  VRAM write address, y*DISPLAY_WIDTH + x (registered)
//   vram_wr_data  VRAM write data (registered)
//   busy          high while clearing or painting
//   clear_done    one-cycle pulse when a clear completes
// ----------------------------------------------------------------------------
module vram_stroke_writer #(
  parameter int                DISPLAY_WIDTH  = 240,
  parameter int                DISPLAY_HEIGHT = 320,
  parameter int                VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT,
  parameter int                VRAM_W         = 16,
  parameter int                BRUSH_R        = 1,
  parameter logic [VRAM_W-1:0] CLEAR_COLOR    = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear_req,
  input  logic                      touch_valid,
  input  logic [8:0]                touch_x,
  input  logic [8:0]                touch_y,
  input  logic [VRAM_W-1:0]         pen_color,
  output logic                      vram_wr_ena,
  output logic [$clog2(VRAM_L)-1:0] vram_wr_addr,
  output logic [VRAM_W-1:0]         vram_wr_data,
  output logic                      busy,
  output logic                      clear_done
);

  localparam int ADDR_W = $clog2(VRAM_L);
  // Signed coordinate width. It must hold a 9-bit coordinate plus the brush
  // offset, including the sign.
  localparam int CW     = 12;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_CLEARING = 2'd1;
  localparam logic [1:0] S_PAINT    = 2'd2;

  localparam logic        [CW-1:0] W_U   = CW'(DISPLAY_WIDTH);
  localparam logic        [CW-1:0] H_U   = CW'(DISPLAY_HEIGHT);
  localparam logic signed [CW-1:0] W_S   = CW'(DISPLAY_WIDTH);
  localparam logic signed [CW-1:0] H_S   = CW'(DISPLAY_HEIGHT);
  localparam logic signed [CW-1:0] POS_R = CW'(BRUSH_R);
  localparam logic signed [CW-1:0] NEG_R = -CW'(BRUSH_R);

  // The clear counter is one bit wider than the address. This lets it reach
  // VRAM_L, which marks "all words written", even when VRAM_L is a power of two.
  localparam logic [ADDR_W:0] CLR_END = (ADDR_W + 1)'(VRAM_L);

  logic [1:0]               state;
  logic [ADDR_W:0]          clr_cnt;
  logic [8:0]               x_q, y_q;
  logic [VRAM_W-1:0]        color_q;
  logic signed [CW-1:0]     dx_q, dy_q;
  logic [8:0]               last_x, last_y;
  logic                     last_valid;

  // Touch acceptance
  logic [CW-1:0] tx_ext, ty_ext;
  logic          touch_in_range, touch_is_last, touch_new;

  assign tx_ext         = {{(CW-9){1'b0}}, touch_x};
  assign ty_ext         = {{(CW-9){1'b0}}, touch_y};
  assign touch_in_range = (tx_ext < W_U) && (ty_ext < H_U);
  assign touch_is_last  = last_valid && (touch_x == last_x) && (touch_y == last_y);
  assign touch_new      = touch_valid && touch_in_range && !touch_is_last;

  // Brush pixel for the current paint iteration
  logic signed [CW-1:0] px, py;
  logic                 pix_in;
  logic [ADDR_W-1:0]    pix_addr;
  logic                 last_iter;

  assign px = $signed({{(CW-9){1'b0}}, x_q}) + dx_q;
  assign py = $signed({{(CW-9){1'b0}}, y_q}) + dy_q;

  // Pixels that fall outside the panel are clipped. They still use their cycle.
  assign pix_in   = !px[CW-1] && (px < W_S) && !py[CW-1] && (py < H_S);
  // The address is formed at full address width so the row product is never
  // truncated. px and py are known non-negative whenever pix_in is set.
  assign pix_addr = ADDR_W'($unsigned(py)) * ADDR_W'(DISPLAY_WIDTH)
                  + ADDR_W'($unsigned(px));
  assign last_iter = (dx_q == POS_R) && (dy_q == POS_R);

  // NOTE: all state is updated with non-blocking assignments, so every
  // right-hand side sees the pre-edge values no matter the statement order.
  // NOTE: the datapath latches (x_q, color_q, ...) are reset along with the
  // control state, so the outputs never carry X after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_CLEARING;
      clr_cnt      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      color_q      <= CLEAR_COLOR;
      dx_q         <= NEG_R;
      dy_q         <= NEG_R;
      last_x       <= '0;
      last_y       <= '0;
      last_valid   <= 1'b0;
      vram_wr_ena  <= 1'b0;
      vram_wr_addr <= '0;
      vram_wr_data <= CLEAR_COLOR;
      busy         <= 1'b1;
      clear_done   <= 1'b0;
    end else begin
      // Write enable and the done pulse default low. Each state raises them
      // only in the cycles where it needs them.
      vram_wr_ena <= 1'b0;
      clear_done  <= 1'b0;

      case (state)
        S_CLEARING: begin
          // clear_req is deliberately not looked at here. A running clear
          // always finishes and is never restarted.
          if (clr_cnt == CLR_END) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            clear_done <= 1'b1;
          end else begin
            vram_wr_ena  <= 1'b1;
            vram_wr_addr <= clr_cnt[ADDR_W-1:0];
            vram_wr_data <= CLEAR_COLOR;
            clr_cnt      <= clr_cnt + 1'b1;
          end
        end

        S_IDLE: begin
          busy <= 1'b0;
          if (clear_req) begin
            state   <= S_CLEARING;
            clr_cnt <= '0;
            busy    <= 1'b1;
          end else begin
            // Once the finger lifts, a touch on the same point counts as new.
            if (!touch_valid) last_valid <= 1'b0;
            if (touch_new) begin
              x_q     <= touch_x;
              y_q     <= touch_y;
              color_q <= pen_color;
              dx_q    <= NEG_R;
              dy_q    <= NEG_R;
              state   <= S_PAINT;
              busy    <= 1'b1;
            end
          end
        end

        S_PAINT: begin
          if (clear_req) begin
            // Abort the stamp. No write is issued in this cycle, and the clear
            // begins at address 0 on the next edge.
            state   <= S_CLEARING;
            clr_cnt <= '0;
          end else begin
            vram_wr_ena <= pix_in;
            if (pix_in) begin
              vram_wr_addr <= pix_addr;
              vram_wr_data <= color_q;
            end
            // Row-major walk over the brush: dx changes fastest.
            if (dx_q == POS_R) begin
              dx_q <= NEG_R;
              if (dy_q != POS_R) dy_q <= dy_q + 1'b1;
            end else begin
              dx_q <= dx_q + 1'b1;
            end
            if (last_iter) begin
              state      <= S_IDLE;
              busy       <= 1'b0;
              last_x     <= x_q;
              last_y     <= y_q;
              last_valid <= 1'b1;
            end
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_stroke_writer.sv
// ----------------------------------------------------------------------------
// tb_vram_stroke_writer
//
// Directed testbench for vram_stroke_writer. The panel is 240 wide, so stamp
// addresses match the full-size panel. The height is reduced to 64 rows, which
// makes VRAM_L = 15360.
// ----------------------------------------------------------------------------
module tb_vram_stroke_writer;

  localparam int TB_WIDTH  = 240;
  localparam int TB_HEIGHT = 64;
  localparam int TB_L      = TB_WIDTH * TB_HEIGHT;
  localparam int TB_AW     = $clog2(TB_L);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clear_req = 1'b0;
  logic              touch_valid = 1'b0;
  logic [8:0]        touch_x = '0;
  logic [8:0]        touch_y = '0;
  logic [15:0]       pen_color = '0;
  logic              vram_wr_ena;
  logic [TB_AW-1:0]  vram_wr_addr;
  logic [15:0]       vram_wr_data;
  logic              busy;
  logic              clear_done;

  int checks   = 0;
  int failures = 0;
  int exp_a [9];

  vram_stroke_writer #(
    .DISPLAY_WIDTH (TB_WIDTH),
    .DISPLAY_HEIGHT(TB_HEIGHT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clear_req   (clear_req),
    .touch_valid (touch_valid),
    .touch_x     (touch_x),
    .touch_y     (touch_y),
    .pen_color   (pen_color),
    .vram_wr_ena (vram_wr_ena),
    .vram_wr_addr(vram_wr_addr),
    .vram_wr_data(vram_wr_data),
    .busy        (busy),
    .clear_done  (clear_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expect n consecutive clear writes, starting at address 0.
  task automatic clear_writes(input string tag, input int n);
    int bad;
    bad = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bad < 0 && !(vram_wr_ena === 1'b1 && vram_wr_addr === TB_AW'(i) &&
                       vram_wr_data === 16'h0000 && busy === 1'b1))
        bad = i;
    end
    check({tag, ".first_bad_index"}, bad, -1);
  endtask

  task automatic clear_finish(input string tag);
    @(negedge clk);
    check({tag, ".end_ena"},   vram_wr_ena, 0);
    check({tag, ".done"},      clear_done,  1);
    check({tag, ".end_busy"},  busy,        0);
    @(negedge clk);
    check({tag, ".done_drop"}, clear_done,  0);
    check({tag, ".idle_ena"},  vram_wr_ena, 0);
  endtask

  // Present a touch and check the 9 paint cycles against exp_a.
  // An entry of -1 means that pixel is clipped, so no write is expected.
  task automatic stamp(input string tag, input logic [8:0] tx, input logic [8:0] ty,
                       input logic [15:0] col);
    touch_valid = 1'b1;
    touch_x     = tx;
    touch_y     = ty;
    pen_color   = col;
    @(negedge clk);
    check({tag, ".accept_busy"}, busy, 1);
    check({tag, ".accept_ena"},  vram_wr_ena, 0);
    pen_color = 16'h1234;  // must not leak into a stamp already under way
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (exp_a[k] >= 0) begin
        check($sformatf("%s.ena%0d", tag, k),  vram_wr_ena, 1);
        check($sformatf("%s.addr%0d", tag, k), vram_wr_addr, exp_a[k]);
        check($sformatf("%s.data%0d", tag, k), vram_wr_data, col);
      end else begin
        check($sformatf("%s.clip%0d", tag, k), vram_wr_ena, 0);
      end
      check($sformatf("%s.busy%0d", tag, k), busy, (k < 8) ? 1 : 0);
    end
  endtask

  // Count write cycles and busy cycles over a quiet window.
  task automatic quiet(input string tag, input int n);
    int wr;
    int bz;
    wr = 0;
    bz = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (vram_wr_ena !== 1'b0) wr++;
      if (busy !== 1'b0) bz++;
    end
    check({tag, ".writes"}, wr, 0);
    check({tag, ".busy"},   bz, 0);
  endtask

  initial begin
    // Reset values while rst is held
    @(negedge clk);
    check("rst.ena",  vram_wr_ena,  0);
    check("rst.addr", vram_wr_addr, 0);
    check("rst.data", vram_wr_data, 16'h0000);
    check("rst.busy", busy,         1);
    check("rst.done", clear_done,   0);
    rst = 1'b0;

    // Clear runs up to address 3000, then an asynchronous reset arrives.
    clear_writes("clr0_partial", 3001);
    rst = 1'b1;
    #1;
    check("midrst.ena",  vram_wr_ena,  0);
    check("midrst.addr", vram_wr_addr, 0);
    check("midrst.busy", busy,         1);
    check("midrst.done", clear_done,   0);
    @(negedge clk);
    rst = 1'b0;
    clear_writes("clr1", TB_L);
    clear_finish("clr1");

    // Basic stamp at (100,50)
    exp_a = '{11859, 11860, 11861, 12099, 12100, 12101, 12339, 12340, 12341};
    stamp("s100_50", 9'd100, 9'd50, 16'hFFFF);
    quiet("held", 100);

    // Move to (101,50)
    exp_a = '{11860, 11861, 11862, 12100, 12101, 12102, 12340, 12341, 12342};
    stamp("s101_50", 9'd101, 9'd50, 16'hF800);

    // Lift the touch, then touch the same point again: it repaints.
    touch_valid = 1'b0;
    @(negedge clk);
    stamp("s101_50_again", 9'd101, 9'd50, 16'h07E0);

    // Corner stamp at (0,0): only 4 of the 9 pixels land on the panel.
    exp_a = '{-1, -1, -1, -1, 0, 1, -1, 240, 241};
    stamp("s0_0", 9'd0, 9'd0, 16'h001F);

    // Out-of-range x is ignored.
    touch_x = 9'd240;
    touch_y = 9'd10;
    quiet("oor_x", 20);

    // clear_req and touch in the same idle cycle: the clear wins.
    clear_req   = 1'b1;
    touch_valid = 1'b1;
    touch_x     = 9'd10;
    touch_y     = 9'd10;
    @(negedge clk);
    check("simul.busy", busy,        1);
    check("simul.ena",  vram_wr_ena, 0);
    clear_req   = 1'b0;
    touch_valid = 1'b0;
    clear_writes("clr2", TB_L);
    clear_finish("clr2");

    // Abort: clear_req arrives on the 3rd paint cycle of a stamp at (50,50).
    touch_valid = 1'b1;
    touch_x     = 9'd50;
    touch_y     = 9'd50;
    pen_color   = 16'hABCD;
    @(negedge clk);
    check("abort.accept_busy", busy, 1);
    @(negedge clk);
    check("abort.wr0_ena",  vram_wr_ena,  1);
    check("abort.wr0_addr", vram_wr_addr, 11809);
    @(negedge clk);
    check("abort.wr1_ena",  vram_wr_ena,  1);
    check("abort.wr1_addr", vram_wr_addr, 11810);
    clear_req = 1'b1;
    @(negedge clk);
    check("abort.gap_ena",  vram_wr_ena, 0);
    check("abort.gap_busy", busy,        1);
    clear_req   = 1'b0;
    touch_valid = 1'b0;
    clear_writes("clr3", TB_L);
    clear_finish("clr3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
